// File: rtl/bcd_time_counter_pkg.sv
// Shared BCD constants and clock-setting state encodings.
package bcd_time_counter_pkg;

  localparam int unsigned BCD_BIT_WIDTH = 4;

  typedef logic [BCD_BIT_WIDTH-1:0] bcd_t;

  localparam bcd_t BCD_ZERO  = 4'd0;
  localparam bcd_t BCD_ONE   = 4'd1;
  localparam bcd_t BCD_TWO   = 4'd2;
  localparam bcd_t BCD_THREE = 4'd3;
  localparam bcd_t BCD_FOUR  = 4'd4;
  localparam bcd_t BCD_FIVE  = 4'd5;
  localparam bcd_t BCD_SIX   = 4'd6;
  localparam bcd_t BCD_SEVEN = 4'd7;
  localparam bcd_t BCD_EIGHT = 4'd8;
  localparam bcd_t BCD_NINE  = 4'd9;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  typedef enum logic [1:0] {
    STATE_RUN      = 2'd0,
    STATE_SET_HOUR = 2'd1,
    STATE_SET_MIN  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_time_counter_if.sv
// Control pulses in, BCD time digits / state / day carry out.
interface bcd_time_counter_if;
  import bcd_time_counter_pkg::*;

  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  bcd_t       sec0;
  bcd_t       sec1;
  bcd_t       min0;
  bcd_t       min1;
  bcd_t       hour0;
  bcd_t       hour1;
  logic [1:0] set_state;
  logic       day_carry;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  sec0, sec1, min0, min1, hour0, hour1, set_state, day_carry
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output sec0, sec1, min0, min1, hour0, hour1, set_state, day_carry
  );

endinterface

// File: rtl/bcd_time_counter_bcd_counter.sv
// Two-digit BCD counter with terminal value TERM_HI:TERM_LO.
// carry is combinational (inc at terminal) so counters cascade on one edge.
module bcd_counter
  import bcd_time_counter_pkg::*;
#(
  parameter bcd_t TERM_HI = BCD_FIVE,
  parameter bcd_t TERM_LO = BCD_NINE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t d0,
  output bcd_t d1,
  output logic carry
);

  logic at_term;

  assign at_term = (d1 == TERM_HI) && (d0 == TERM_LO);
  assign carry   = inc && at_term;

  // Digit registers: clear, wrap at terminal, or BCD increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= BCD_ZERO;
      d1 <= BCD_ZERO;
    end else if (clr) begin
      d0 <= BCD_ZERO;
      d1 <= BCD_ZERO;
    end else if (inc) begin
      if (at_term) begin
        d0 <= BCD_ZERO;
        d1 <= BCD_ZERO;
      end else if (d0 >= BCD_NINE) begin
        d0 <= BCD_ZERO;
        d1 <= d1 + BCD_ONE;
      end else begin
        d0 <= d0 + BCD_ONE;
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour BCD clock: run/set state machine and increment/carry routing
// around three two-digit counters.
module bcd_time_counter
  import bcd_time_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  bcd_time_counter_if.slave  bus
);

  state_t state;
  state_t state_nxt;

  logic is_run;
  logic is_set_hour;
  logic is_set_min;
  logic inc_ok;
  logic sec_inc;
  logic sec_clr;
  logic min_inc;
  logic hour_inc;
  logic sec_carry;
  logic min_carry;
  logic hour_carry;
  logic day_carry_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= STATE_RUN;
    else        state <= state_nxt;
  end

  // Next state: btn_mode cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
  always_comb begin
    state_nxt = STATE_RUN;
    case (state)
      STATE_RUN:      state_nxt = bus.btn_mode ? STATE_SET_HOUR : STATE_RUN;
      STATE_SET_HOUR: state_nxt = bus.btn_mode ? STATE_SET_MIN  : STATE_SET_HOUR;
      STATE_SET_MIN:  state_nxt = bus.btn_mode ? STATE_RUN      : STATE_SET_MIN;
      default:        state_nxt = STATE_RUN;
    endcase
  end

  // btn_mode takes priority, so a coincident btn_inc is dropped.
  assign is_run      = (state == STATE_RUN);
  assign is_set_hour = (state == STATE_SET_HOUR);
  assign is_set_min  = (state == STATE_SET_MIN);
  assign inc_ok      = bus.btn_inc && !bus.btn_mode;

  assign sec_inc  = is_run && bus.tick_1hz;
  assign sec_clr  = is_set_min && bus.btn_mode;
  assign min_inc  = is_run ? sec_carry : (is_set_min && inc_ok);
  assign hour_inc = is_run ? min_carry : (is_set_hour && inc_ok);

  // Day rollover pulse; hour wraps while setting are not day rollovers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) day_carry_q <= DISABLED;
    else        day_carry_q <= is_run && hour_carry;
  end

  assign bus.day_carry = day_carry_q;
  assign bus.set_state = state;

  bcd_counter #(.TERM_HI(BCD_FIVE), .TERM_LO(BCD_NINE)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .d0    (bus.sec0),
    .d1    (bus.sec1),
    .carry (sec_carry)
  );

  bcd_counter #(.TERM_HI(BCD_FIVE), .TERM_LO(BCD_NINE)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (DISABLED),
    .d0    (bus.min0),
    .d1    (bus.min1),
    .carry (min_carry)
  );

  bcd_counter #(.TERM_HI(BCD_TWO), .TERM_LO(BCD_THREE)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .clr   (DISABLED),
    .d0    (bus.hour0),
    .d1    (bus.hour1),
    .carry (hour_carry)
  );

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: vector table, directed corner sequences,
// full-day run and random stimulus against a seconds-of-day model.
module tb_bcd_time_counter;

  logic clk;
  logic rst_n;

  bcd_time_counter_if bus ();

  bcd_time_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: time as seconds of day, state as 0/1/2.
  int m_t;
  int m_st;
  bit m_dc;

  typedef struct {
    bit tick;
    bit mode;
    bit inc;
    int h;
    int m;
    int s;
    int st;
    bit dc;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [23:0] enc(int h, int m, int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] enc_t(int t);
    return enc(t / 3600, (t / 60) % 60, t % 60);
  endfunction

  function automatic logic [23:0] dut_time();
    return {bus.hour1, bus.hour0, bus.min1, bus.min0, bus.sec1, bus.sec0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit tick, input bit mode, input bit inc);
    int h;
    int mi;
    m_dc = 1'b0;
    case (m_st)
      0: begin
        if (tick) begin
          if (m_t == 86399) m_dc = 1'b1;
          m_t = (m_t + 1) % 86400;
        end
        if (mode) m_st = 1;
      end
      1: begin
        if (mode) m_st = 2;
        else if (inc) begin
          h   = m_t / 3600;
          m_t = m_t - h * 3600 + ((h + 1) % 24) * 3600;
        end
      end
      default: begin
        if (mode) begin
          m_st = 0;
          m_t  = m_t - (m_t % 60);
        end else if (inc) begin
          mi  = (m_t / 60) % 60;
          m_t = m_t + (((mi + 1) % 60) - mi) * 60;
        end
      end
    endcase
  endtask

  task automatic drive(input bit tick, input bit mode, input bit inc);
    @(negedge clk);
    bus.tick_1hz = tick;
    bus.btn_mode = mode;
    bus.btn_inc  = inc;
    @(posedge clk);
    #1;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  task automatic step(input bit tick, input bit mode, input bit inc);
    drive(tick, mode, inc);
    model_step(tick, mode, inc);
    chk("time", 32'(dut_time()), 32'(enc_t(m_t)));
    chk("state", 32'(bus.set_state), 32'(m_st));
    chk("day_carry", 32'(bus.day_carry), 32'(m_dc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("reset_time", 32'(dut_time()), 32'h0);
    chk("reset_state", 32'(bus.set_state), 32'h0);
    chk("reset_dc", 32'(bus.day_carry), 32'h0);
    m_t  = 0;
    m_st = 0;
    m_dc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset, then reach h:m:s through the set states and tick_1hz.
  task automatic set_time(input int h, input int m, input int s);
    do_reset();
    step(0, 1, 0);
    repeat (h) step(0, 0, 1);
    step(0, 1, 0);
    repeat (m) step(0, 0, 1);
    step(0, 1, 0);
    repeat (s) step(1, 0, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int dc_seen;
    rst_n        = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;

    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, 0, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 1, 1, 0};
    tbl[4]  = '{0, 0, 1, 1, 0, 1, 1, 0};
    tbl[5]  = '{0, 1, 1, 1, 0, 1, 2, 0};
    tbl[6]  = '{0, 0, 1, 1, 1, 1, 2, 0};
    tbl[7]  = '{1, 0, 1, 1, 2, 1, 2, 0};
    tbl[8]  = '{0, 1, 0, 1, 2, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 1, 2, 1, 1, 0};
    tbl[10] = '{0, 1, 0, 1, 2, 1, 2, 0};
    tbl[11] = '{0, 1, 0, 1, 2, 0, 0, 0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].tick, tbl[i].mode, tbl[i].inc);
      chk($sformatf("tbl%0d_time", i), 32'(dut_time()), 32'(enc(tbl[i].h, tbl[i].m, tbl[i].s)));
      chk($sformatf("tbl%0d_state", i), 32'(bus.set_state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_dc", i), 32'(bus.day_carry), 32'(tbl[i].dc));
    end

    // 23:59:58 -> 23:59:59 -> 00:00:00 with a single day_carry cycle.
    set_time(23, 59, 58);
    step(1, 0, 0);
    chk("wrap_a_time", 32'(dut_time()), 32'(enc(23, 59, 59)));
    chk("wrap_a_dc", 32'(bus.day_carry), 32'h0);
    step(1, 0, 0);
    chk("wrap_b_time", 32'(dut_time()), 32'h0);
    chk("wrap_b_dc", 32'(bus.day_carry), 32'h1);
    step(0, 0, 0);
    chk("wrap_c_dc", 32'(bus.day_carry), 32'h0);

    // Hour setting wraps 23 -> 00 without day_carry; ticks are frozen out.
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    dc_seen = 0;
    for (int i = 0; i < 25; i++) begin
      step(0, 0, 1);
      dc_seen += int'(bus.day_carry);
    end
    chk("sethour_time", 32'(dut_time()), 32'(enc(1, 0, 1)));
    chk("sethour_dc_count", 32'(dc_seen), 32'h0);
    repeat (3) step(1, 0, 0);
    chk("sethour_frozen", 32'(dut_time()), 32'(enc(1, 0, 1)));

    // Minute setting wraps 59 -> 00 without hour carry; exit clears seconds.
    set_time(12, 59, 37);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("setmin_enter", 32'(dut_time()), 32'(enc(12, 59, 37)));
    step(0, 0, 1);
    chk("setmin_wrap", 32'(dut_time()), 32'(enc(12, 0, 37)));
    step(0, 1, 0);
    chk("setmin_exit", 32'(dut_time()), 32'(enc(12, 0, 0)));
    chk("setmin_exit_st", 32'(bus.set_state), 32'h0);

    // Coincident pulses.
    do_reset();
    step(0, 1, 1);
    chk("modeinc_state", 32'(bus.set_state), 32'h1);
    chk("modeinc_time", 32'(dut_time()), 32'h0);
    set_time(10, 0, 9);
    step(1, 1, 0);
    chk("tickmode_time", 32'(dut_time()), 32'(enc(10, 0, 10)));
    chk("tickmode_state", 32'(bus.set_state), 32'h1);

    // Asynchronous reset mid-cycle while in SET_MIN.
    set_time(7, 45, 12);
    step(0, 1, 0);
    step(0, 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_time", 32'(dut_time()), 32'h0);
    chk("async_state", 32'(bus.set_state), 32'h0);
    chk("async_dc", 32'(bus.day_carry), 32'h0);
    m_t  = 0;
    m_st = 0;
    m_dc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0);
    chk("after_rst", 32'(dut_time()), 32'(enc(0, 0, 1)));

    // Randomized stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    end

    // Full day from reset.
    do_reset();
    dc_seen = 0;
    for (int i = 0; i < 86400; i++) begin
      step(1, 0, 0);
      dc_seen += int'(bus.day_carry);
    end
    chk("day_final_time", 32'(dut_time()), 32'h0);
    chk("day_final_dc", 32'(bus.day_carry), 32'h1);
    chk("day_dc_count", 32'(dc_seen), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
